// File: rtl/hif_fir_engine_if.sv
// Burst sample, coefficient ROM and result signals of the FIR engine.
// master drives the burst and ROM data; slave is the engine.
interface hif_fir_engine_if #(
    parameter int unsigned CW = 10
);
    logic                 sequencing;
    logic signed [15:0]   smpl_in;
    logic        [CW-1:0] coeff_addr;
    logic signed [15:0]   coeff;
    logic signed [15:0]   smpl_out;
    logic                 vld;
    logic                 seq_err;

    modport master (
        output sequencing, smpl_in, coeff,
        input  coeff_addr, smpl_out, vld, seq_err
    );

    modport slave (
        input  sequencing, smpl_in, coeff,
        output coeff_addr, smpl_out, vld, seq_err
    );
endinterface

// File: rtl/hif_fir_engine.sv
// Burst FIR engine: one MAC per accepted sample against an external ROM.
// Emits one rounded, saturated result per full burst and flags short bursts.
module hif_fir_engine #(
    parameter int unsigned NTAPS = 1021,
    parameter int unsigned CW    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    hif_fir_engine_if.slave   fif
);
    typedef enum logic [2:0] {StIdle, StAcc, StFlush, StOut, StWaitLow} state_e;

    localparam logic [CW:0] LastTap = (CW+1)'(NTAPS - 1);

    state_e             state_q, state_d;
    logic [CW:0]        k_q, k_d;
    logic signed [41:0] acc_q, acc_d;
    logic signed [15:0] smpl_q, smpl_d;
    logic signed [15:0] smpl_out_q, smpl_out_d;
    logic               vld_q, vld_d;
    logic               seq_err_q, seq_err_d;

    logic signed [31:0] prod;
    logic signed [41:0] acc_sum;
    logic signed [41:0] rnd;
    logic signed [15:0] sat;

    // Registered sample meets the ROM word addressed in the same cycle it was taken.
    assign prod    = smpl_q * fif.coeff;
    assign acc_sum = acc_q + 42'(prod);
    assign rnd     = (acc_sum + 42'sd16384) >>> 15;

    always_comb begin
        sat = rnd[15:0];
        if (rnd > 42'sd32767) begin
            sat = 16'sh7fff;
        end else if (rnd < -42'sd32768) begin
            sat = 16'sh8000;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        acc_d      = acc_q;
        smpl_d     = smpl_q;
        smpl_out_d = smpl_out_q;
        vld_d      = 1'b0;
        seq_err_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                k_d = '0;
                if (fif.sequencing) begin
                    state_d = StAcc;
                    k_d     = (CW+1)'(1);
                    acc_d   = '0;
                    smpl_d  = fif.smpl_in;
                end
            end
            StAcc: begin
                if (fif.sequencing) begin
                    acc_d  = acc_sum;
                    smpl_d = fif.smpl_in;
                    k_d    = k_q + (CW+1)'(1);
                    if (k_q == LastTap) begin
                        state_d = StFlush;
                    end
                end else begin
                    state_d   = StIdle;
                    k_d       = '0;
                    seq_err_d = 1'b1;
                end
            end
            StFlush: begin
                // Result is registered on the way into OUT so vld and smpl_out
                // are both flop outputs for the whole OUT cycle.
                acc_d      = acc_sum;
                smpl_out_d = sat;
                vld_d      = 1'b1;
                state_d    = StOut;
            end
            StOut: begin
                if (fif.sequencing) begin
                    state_d = StWaitLow;
                end else begin
                    state_d = StIdle;
                    k_d     = '0;
                end
            end
            StWaitLow: begin
                if (!fif.sequencing) begin
                    state_d = StIdle;
                    k_d     = '0;
                end
            end
            default: begin
                state_d = StIdle;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            k_q        <= '0;
            acc_q      <= '0;
            smpl_q     <= '0;
            smpl_out_q <= '0;
            vld_q      <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            smpl_q     <= smpl_d;
            smpl_out_q <= smpl_out_d;
            vld_q      <= vld_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign fif.coeff_addr = k_q[CW-1:0];
    assign fif.smpl_out   = smpl_out_q;
    assign fif.vld        = vld_q;
    assign fif.seq_err    = seq_err_q;
endmodule

// File: doc/hif_fir_engine.md
HIF_FIR_ENGINE -- requirements
Module: hif_fir_engine

Interface
REQ-001 The block SHALL have parameter NTAPS, default 1021, meaning taps per burst; it is also the burst length.
REQ-002 The block SHALL have parameter CW, default 10, meaning coeff_addr width; 2^CW SHALL be at least NTAPS.
REQ-003 Port clk SHALL be an input, width 1, and is the single system clock; all logic is rising-edge.
REQ-004 Port rst_n SHALL be an input, width 1: asynchronous, active-low reset.
REQ-005 Port sequencing SHALL be an input, width 1: a burst is in progress and smpl_in is valid this cycle.
REQ-006 Port smpl_in SHALL be an input, signed, width 16: burst sample, oldest first.
REQ-007 Port coeff_addr SHALL be an output, width CW: address to the external coefficient ROM.
REQ-008 Port coeff SHALL be an input, signed Q1.15, width 16: ROM data, valid one cycle after coeff_addr.
REQ-009 Port smpl_out SHALL be an output, signed, width 16: filtered sample, held between updates.
REQ-010 Port vld SHALL be an output, width 1: one-cycle pulse marking a new smpl_out.
REQ-011 Port seq_err SHALL be an output, width 1: one-cycle pulse when a burst ends short.

Function
REQ-012 The block SHALL implement states IDLE, ACC, FLUSH, OUT and WAIT_LOW.
REQ-013 The tap counter k SHALL be CW+1 bits wide; coeff_addr SHALL equal k[CW-1:0] in every state and SHALL equal 0 in IDLE.
REQ-014 Transition IDLE->ACC: sequencing=1 while in IDLE; that cycle is tap 0, k becomes 1 and the accumulator clears.
REQ-015 In ACC, each cycle with sequencing=1 SHALL accept tap k, and k SHALL increment.
REQ-016 Sample k SHALL be registered for one cycle and multiplied with coeff (c_k) in the following cycle; the 32-bit product SHALL be added to a 42-bit signed accumulator in that same cycle.
REQ-017 Transition ACC->FLUSH SHALL occur on the cycle tap NTAPS-1 is accepted; FLUSH SHALL last one cycle and perform the final accumulate.
REQ-018 In OUT, the block SHALL compute r = (acc + 2^14) >>> 15, arithmetic shift.
REQ-019 In OUT, r SHALL saturate to [-32768, 32767] and be loaded into smpl_out, with vld=1 for exactly that one cycle.
REQ-020 Latency: vld SHALL assert exactly 2 cycles after the cycle in which tap NTAPS-1 is accepted.
REQ-021 Transition OUT->WAIT_LOW SHALL occur if sequencing=1; otherwise OUT->IDLE.
REQ-022 In WAIT_LOW, samples SHALL be ignored (no accumulate, k frozen) until sequencing=0, then the state SHALL go to IDLE.
REQ-023 A new burst SHALL require at least one cycle of sequencing=0 after the previous burst.
REQ-024 Short burst: if sequencing=0 in ACC before NTAPS taps are accepted, seq_err SHALL pulse for one cycle, vld SHALL NOT assert, smpl_out SHALL be unchanged, and the state SHALL go to IDLE.
REQ-025 Samples with sequencing=1 arriving during FLUSH or OUT SHALL be ignored.
REQ-026 vld and seq_err SHALL never be high in the same cycle.
REQ-027 Accumulation SHALL never overflow for 16x16 inputs at NTAPS <= 1024; no intermediate wrap is permitted.

Reset
REQ-028 When rst_n=0, the state SHALL be IDLE and k, accumulator, sample register, smpl_out, vld and seq_err SHALL all be 0, immediately and asynchronously.
REQ-029 Reset asserted mid-burst SHALL discard the partial sum; after release the block SHALL wait in IDLE and SHALL start only on a fresh sequencing=1 seen in IDLE.
REQ-030 A burst still high at reset release SHALL be treated as starting at tap 0 on the first clock.

Verification
REQ-031 Impulse: ROM c_0=0x4000, all other c_k=0; burst s_0=1000, rest 0 -> smpl_out=500, vld one cycle, 2 cycles after tap 1020.
REQ-032 Positive saturation: all c=0x7FFF, all s=0x7FFF, full burst -> smpl_out=0x7FFF, seq_err=0.
REQ-033 Negative saturation: all c=0x7FFF, all s=0x8000, full burst -> smpl_out=0x8000.
REQ-034 Short burst: sequencing drops after 500 taps -> one seq_err pulse, no vld, smpl_out holds its prior value, state IDLE.
REQ-035 Long burst plus back-to-back: sequencing high for 1100 cycles (extra samples 0x7FFF), then one cycle low, then a second impulse burst -> first result unaffected by the extra samples, second vld with smpl_out=500.
REQ-036 Reset at tap 300, then a full impulse burst -> smpl_out and vld are 0 during reset, then the correct result of 500 with no residue from the aborted burst.
